// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Two-port round-robin arbiter in front of a single-ported memory with a
//   combinational read path. Every transaction takes three cycles:
//   IDLE (arbitrate and latch) -> ACCESS (one memory strobe) -> DONE (ack).
//   The winner's request is latched on grant, so a requester may drop req
//   after it has been granted and the access still completes.
//
// Parameters:
//   DEPTH   number of memory words (valid addresses 0..DEPTH-1)
//   DATA_W  data and address width
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   req0/req1             access request per port
//   we0/we1               1 = write, 0 = read
//   addr0/addr1           word address per port
//   wdata0/wdata1         write data per port
//   ack0/ack1             one-cycle completion pulse (DONE cycle)
//   rdata0/rdata1         registered read data, held until the next read
//   mem_addr/mem_wdata    shared memory address / write data (0 outside ACCESS)
//   mem_write/mem_read    shared memory strobes (ACCESS cycle only)
//   mem_rdata             combinational read data from memory
//   busy                  high whenever the FSM is not in IDLE
//   err                   (ARB_RANGE_CHECK_EN only) pulses with ack when the
//                         granted address was >= DEPTH
//
// Build option:
//   `define ARB_RANGE_CHECK_EN to add the address range check and err port.
//   Without it every address is passed to memory unchecked.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef ARB_RANGE_CHECK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic              any_req;
  logic              gnt_next;
  logic              gnt;
  logic              lg;
  logic              lat_we;
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              addr_ok;

  assign any_req = req0 | req1;

  // Round-robin pick. On a tie the port that did not win last time goes
  // next; otherwise the single requester wins. With no request the value
  // is irrelevant because nothing is latched.
  always_comb begin
    if (req0 && req1) begin
      gnt_next = ~lg;
    end else begin
      gnt_next = req1;
    end
  end

`ifdef ARB_RANGE_CHECK_EN
  // Compare one bit wider than the address so DEPTH == 2**DATA_W still works.
  localparam logic [DATA_W:0] DEPTH_EXT = (DATA_W + 1)'(DEPTH);

  assign addr_ok = ({1'b0, lat_addr} < DEPTH_EXT);
`else
  assign addr_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a requester
  // still holding req during DONE is seen again in the following IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant and request latch. lg resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lg        <= 1'b1;
      gnt       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      lg        <= gnt_next;
      gnt       <= gnt_next;
      lat_we    <= gnt_next ? we1    : we0;
      lat_addr  <= gnt_next ? addr1  : addr0;
      lat_wdata <= gnt_next ? wdata1 : wdata0;
    end
  end

  // Read data capture at the end of ACCESS. Writes and rejected addresses
  // leave both rdata registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS && !lat_we && addr_ok) begin
      if (gnt) begin
        rdata1 <= mem_rdata;
      end else begin
        rdata0 <= mem_rdata;
      end
    end
  end

  // Outputs decoded from state. The memory bus is driven only during an
  // accepted ACCESS cycle and is all-zero otherwise.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = (state != IDLE);
`ifdef ARB_RANGE_CHECK_EN
    err       = 1'b0;
`endif
    case (state)
      ACCESS: begin
        if (addr_ok) begin
          mem_write = lat_we;
          mem_read  = ~lat_we;
          mem_addr  = lat_addr;
          mem_wdata = lat_wdata;
        end
      end
      DONE: begin
        ack0 = ~gnt;
        ack1 = gnt;
`ifdef ARB_RANGE_CHECK_EN
        err  = ~addr_ok;
`endif
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Scoreboard bench for mem_arbiter. The stimulus side decides which ports
//   request and, from the round-robin rule and a reference memory, pushes
//   the expected transactions in service order. A monitor on the falling
//   edge compares memory strobes and acks against the queue head.
//   Includes a small behavioural memory driving mem_rdata.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);

  logic              clk;
  logic              rst_n;
  logic              req0, req1, we0, we1;
  logic [DATA_W-1:0] addr0, addr1, wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              mem_write, mem_read;
  logic              busy;
`ifdef ARB_RANGE_CHECK_EN
  logic              err;
`endif

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          bad;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] refMem [DEPTH];
  logic [31:0] envMem [DEPTH];
  logic [31:0] shadow [2];
  bit          lastGrant;
  bit          strobeSeen;
  int          checkCount;
  int          failCount;
  int          cyc;
  int          lastAckCyc;

  mem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef ARB_RANGE_CHECK_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory seen by the DUT.
  always_comb begin
    mem_rdata = (mem_addr < DEPTH) ? envMem[mem_addr[AW-1:0]] : '0;
  end

  always @(posedge clk) begin
    if (mem_write && mem_addr < DEPTH) envMem[mem_addr[AW-1:0]] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic failNow(input string name, input int act, input int expv);
    checkCount++;
    failCount++;
    $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Reference model: applies one access in service order.
  function automatic void pushOp(input bit port, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = '0;
`ifdef ARB_RANGE_CHECK_EN
    e.bad   = (addr >= DEPTH);
`else
    e.bad   = 1'b0;
`endif
    if (!e.bad) begin
      if (we) refMem[addr[AW-1:0]] = wdata;
      else    e.rdata = refMem[addr[AW-1:0]];
    end
    expQ.push_back(e);
    lastGrant = port;
  endfunction

  function automatic void flushModel();
    expQ.delete();
    strobeSeen = 1'b0;
  endfunction

  // Monitor: compares every strobe and ack against the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_read || mem_write) begin
      if (expQ.size() == 0) begin
        failNow("strobe_unexpected", 1, 0);
      end else begin
        checkOutput("strobe_once", strobeSeen, 0);
        checkOutput("mem_write", mem_write, expQ[0].we);
        checkOutput("mem_read", mem_read, !expQ[0].we);
        checkOutput("mem_addr", mem_addr, expQ[0].addr);
        checkOutput("mem_wdata", mem_wdata, expQ[0].wdata);
        strobeSeen = 1'b1;
      end
    end else begin
      checkOutput("idle_mem_addr", mem_addr, 0);
      checkOutput("idle_mem_wdata", mem_wdata, 0);
    end
    if (ack0 || ack1) begin
      checkOutput("ack_one_hot", ack0 & ack1, 0);
      if (expQ.size() == 0) begin
        failNow("ack_unexpected", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("ack_port", ack1, e.port);
        checkOutput("access_strobe", strobeSeen, !e.bad);
        strobeSeen = 1'b0;
        if (!e.we && !e.bad) shadow[e.port] = e.rdata;
`ifdef ARB_RANGE_CHECK_EN
        checkOutput("err_pulse", err, e.bad);
`endif
      end
      checkOutput("rdata0_ack", rdata0, shadow[0]);
      checkOutput("rdata1_ack", rdata1, shadow[1]);
      lastAckCyc = cyc;
    end else begin
      checkOutput("rdata0_hold", rdata0, shadow[0]);
      checkOutput("rdata1_hold", rdata1, shadow[1]);
`ifdef ARB_RANGE_CHECK_EN
      checkOutput("err_quiet", err, 0);
`endif
    end
  end

  // One round: the selected ports raise req from IDLE and hold it until
  // their ack (or, with earlyDrop and a single port, until the grant).
  task automatic applyStimulus(input bit r0, input bit r1,
                               input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                               input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                               input bit earlyDrop);
    bit pend0, pend1, gotFirst;
    int raiseCyc, firstCyc;
    @(negedge clk);
    if (r0 && r1) begin
      if (lastGrant) begin
        pushOp(0, w0, a0, d0);
        pushOp(1, w1, a1, d1);
      end else begin
        pushOp(1, w1, a1, d1);
        pushOp(0, w0, a0, d0);
      end
    end else if (r0) begin
      pushOp(0, w0, a0, d0);
    end else if (r1) begin
      pushOp(1, w1, a1, d1);
    end
    we0 = w0; addr0 = a0; wdata0 = d0;
    we1 = w1; addr1 = a1; wdata1 = d1;
    req0 = r0; req1 = r1;
    pend0 = r0; pend1 = r1;
    gotFirst = 1'b0;
    raiseCyc = cyc;
    firstCyc = 0;
    for (int i = 0; i < 12 && (pend0 || pend1); i++) begin
      @(negedge clk);
      if (earlyDrop && !(r0 && r1) && (mem_read || mem_write)) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      if ((ack0 && pend0) || (ack1 && pend1)) begin
        if (!gotFirst) begin
          checkOutput("ack_latency", cyc - raiseCyc, 2);
          gotFirst = 1'b1;
          firstCyc = cyc;
        end else begin
          checkOutput("ack_spacing", cyc - firstCyc, 3);
        end
        if (ack0) begin pend0 = 1'b0; req0 = 1'b0; end
        if (ack1) begin pend1 = 1'b0; req1 = 1'b0; end
      end
    end
    if (pend0 || pend1) begin
      failNow("ack_timeout", {pend0, pend1}, 0);
      req0 = 1'b0;
      req1 = 1'b0;
      flushModel();
    end
  endtask

  // Both ports hold req for a fixed number of grants.
  task automatic holdBoth(input int grants);
    int acks, prevCyc;
    @(negedge clk);
    for (int k = 0; k < grants; k++) begin
      if (lastGrant) pushOp(0, 1'b1, 32'd6, 32'hCAFE0006);
      else           pushOp(1, 1'b0, 32'd6, 32'h0);
    end
    we0 = 1'b1; addr0 = 32'd6; wdata0 = 32'hCAFE0006;
    we1 = 1'b0; addr1 = 32'd6; wdata1 = 32'h0;
    req0 = 1'b1; req1 = 1'b1;
    acks = 0;
    prevCyc = 0;
    for (int i = 0; i < grants * 3 + 6 && acks < grants; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        if (acks > 0) checkOutput("hold_spacing", cyc - prevCyc, 3);
        prevCyc = cyc;
        acks++;
        if (acks == grants) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    if (acks != grants) begin
      failNow("hold_timeout", acks, grants);
      req0 = 1'b0;
      req1 = 1'b0;
      flushModel();
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_ack0"}, ack0, 0);
    checkOutput({tag, "_ack1"}, ack1, 0);
    checkOutput({tag, "_rdata0"}, rdata0, 0);
    checkOutput({tag, "_rdata1"}, rdata1, 0);
    checkOutput({tag, "_mem_read"}, mem_read, 0);
    checkOutput({tag, "_mem_write"}, mem_write, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    int mask;
    checkCount = 0; failCount = 0; cyc = 0; lastAckCyc = 0;
    lastGrant = 1'b1; strobeSeen = 1'b0;
    shadow[0] = '0; shadow[1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v = 32'(i * 13 + 7);
      refMem[i] = v;
      envMem[i] = v;
    end
    refMem[0] = 32'd65;  envMem[0] = 32'd65;
    refMem[1] = 32'd110; envMem[1] = 32'd110;
    refMem[2] = 32'd103; envMem[2] = 32'd103;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    $display("[TB] tie right after reset: port 0 first");
    applyStimulus(1, 1, 0, 32'd0, 32'd0, 0, 32'd2, 32'd0, 0);
    checkOutput("tie_rdata0", rdata0, 32'd65);
    checkOutput("tie_rdata1", rdata1, 32'd103);

    $display("[TB] single read port 0 addr 1");
    applyStimulus(1, 0, 0, 32'd1, 32'd0, 0, 32'd0, 32'd0, 0);
    checkOutput("read1_rdata0", rdata0, 32'd110);

    $display("[TB] port 1 write then port 0 read");
    applyStimulus(0, 1, 0, 32'd0, 32'd0, 1, 32'd5, 32'hDEAD, 0);
    applyStimulus(1, 0, 0, 32'd5, 32'd0, 0, 32'd0, 32'd0, 0);
    checkOutput("wr_rd_rdata0", rdata0, 32'hDEAD);
    checkOutput("wr_rd_rdata1", rdata1, 32'd103);

    $display("[TB] both ports holding req");
    holdBoth(6);

    $display("[TB] randomized rounds");
    for (int n = 0; n < 40; n++) begin
      mask = $urandom_range(1, 3);
      applyStimulus(mask[0], mask[1],
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom,
                    (mask != 3) && ($urandom_range(0, 1) == 1));
    end

    $display("[TB] reset during ACCESS");
    @(negedge clk);
    pushOp(0, 1'b0, 32'd3, 32'h55);
    we0 = 1'b0; addr0 = 32'd3; wdata0 = 32'h55; req0 = 1'b1;
    @(negedge clk);
    checkOutput("pre_reset_access", mem_read, 1);
    #2;
    rst_n = 1'b0;
    req0 = 1'b0;
    flushModel();
    shadow[0] = '0; shadow[1] = '0;
    lastGrant = 1'b1;
    #1;
    checkResetState("midreset");
    repeat (2) @(negedge clk);
    checkOutput("midreset_no_ack0", ack0, 0);
    rst_n = 1'b1;

    $display("[TB] tie after mid-access reset");
    applyStimulus(1, 1, 0, 32'd0, 32'd0, 0, 32'd2, 32'd0, 0);

`ifdef ARB_RANGE_CHECK_EN
    $display("[TB] out-of-range read");
    applyStimulus(1, 0, 0, 32'd40, 32'd0, 0, 32'd0, 32'd0, 0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of memory words (valid addresses 0..DEPTH-1).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data and address width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports req0/req1, input, 1 bit each: requester n asks for one memory access.
REQ-006 SHALL have ports we0/we1, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1, input, DATA_W bits each: word address.
REQ-008 SHALL have ports wdata0/wdata1, input, DATA_W bits each: write data.
REQ-009 SHALL have ports ack0/ack1, output, 1 bit each: one-cycle completion pulse.
REQ-010 SHALL have ports rdata0/rdata1, output, DATA_W bits each: registered read data.
REQ-011 SHALL have ports mem_addr/mem_wdata, output, DATA_W bits each: shared memory address and write data.
REQ-012 SHALL have ports mem_write/mem_read, output, 1 bit each: shared memory strobes.
REQ-013 SHALL have port mem_rdata, input, DATA_W bits: combinational read data from memory.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; IDLE stays put while req0=req1=0.
REQ-016 SHALL sample req/we/addr/wdata only in IDLE and latch the winner's we/addr/wdata into internal registers on the IDLE->ACCESS edge.
REQ-017 SHALL arbitrate round-robin with last-grant pointer lg: single requester wins; on simultaneous req0=req1=1 the port != lg wins; lg updates to the winner.
REQ-018 SHALL assert exactly one of mem_write/mem_read for exactly the one ACCESS cycle, driving the latched mem_addr/mem_wdata; outside ACCESS, both strobes, mem_addr, and mem_wdata are 0.
REQ-019 SHALL capture mem_rdata into rdata of the granted port at the end of ACCESS for reads; writes leave rdata unchanged.
REQ-020 SHALL pulse ack of the granted port for exactly the DONE cycle; the other ack stays 0.
REQ-021 SHALL hold rdataN stable from DONE until the next read completion on that port.
REQ-022 SHALL give latency: req seen at edge N -> ACCESS cycle N+1 -> ack high cycle N+2; back-to-back throughput is 1 access per 3 cycles.
REQ-023 SHALL not abort a transaction if req drops after grant; the access completes and ack still pulses.
REQ-024 SHALL not accept a new request in DONE; a requester still holding req after ack is treated as a new request in the following IDLE.

Reset
REQ-025 SHALL, on rst_n=0 at any time, asynchronously force IDLE, lg=1 (port 0 wins first tie), ack0=ack1=0, mem strobes/addr/wdata=0, rdata0=rdata1=0, and busy=0.
REQ-026 SHALL drop an in-flight transaction on reset without ack; the requester reissues it.

Configuration
REQ-027 SHALL, with ARB_RANGE_CHECK_EN defined, add output err (1 bit): a granted address >= DEPTH skips memory strobes in ACCESS, pulses err together with ack in DONE, and leaves rdata unchanged.
REQ-028 SHALL, without ARB_RANGE_CHECK_EN, have no err port and pass every address through unchecked.

Verification
REQ-029 Port 0 read addr=1 alone -> mem_read high 1 cycle with mem_addr=1; ack0 two cycles after the req edge; rdata0=110.
REQ-030 req0 and req1 both reading addr 0 and 2 right after reset -> port 0 served first (rdata0=65), then port 1 (rdata1=103); acks 3 cycles apart.
REQ-031 Port 1 write addr=5 data=0xDEAD, then port 0 read addr=5 -> mem_write exactly 1 cycle; rdata0=0xDEAD; rdata1 unchanged.
REQ-032 Both ports hold req continuously for 6 grants -> grants alternate 0,1,0,1,0,1; mem_read and mem_write are never both high.
REQ-033 rst_n low during ACCESS of a port 0 read -> immediate IDLE, no ack0, rdata0=0, strobes 0.
REQ-034 With ARB_RANGE_CHECK_EN, read addr=40 -> no strobe; err and ack pulse together; rdata unchanged.
